// File: rtl/alu_seq_ctrl.sv
// Sequencer that runs a 2*HW-bit operation through a single HW-bit ALU,
// low half first and then (for wide operations) high half with carry chaining.
module alu_seq_ctrl #(
    parameter int HW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2*HW-1:0] req_a,
    input  logic [2*HW-1:0] req_b,
    input  logic [3:0]      req_sel,
    input  logic            req_c_in,
    input  logic            req_wide,
    output logic [HW-1:0]   alu_a_in,
    output logic [HW-1:0]   alu_b_in,
    output logic            alu_c_in,
    output logic [3:0]      alu_sel,
    input  logic [HW-1:0]   alu_out,
    input  logic            alu_c_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*HW-1:0] rsp_out,
    output logic            rsp_c_out,
    output logic            busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic [2*HW-1:0] a_q,      a_d;
    logic [2*HW-1:0] b_q,      b_d;
    logic [3:0]      sel_q,    sel_d;
    logic            cin_q,    cin_d;
    logic            wide_q,   wide_d;
    logic [2*HW-1:0] result_q, result_d;
    logic            carry_q,  carry_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        cin_d    = cin_q;
        wide_d   = wide_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = LO;
                    a_d     = req_a;
                    b_d     = req_b;
                    sel_d   = req_sel;
                    cin_d   = req_c_in;
                    wide_d  = req_wide;
                end
            end
            LO: begin
                result_d[HW-1:0] = alu_out;
                carry_d          = alu_c_out;
                if (wide_q) begin
                    state_d = HI;
                end else begin
                    result_d[2*HW-1:HW] = '0;
                    state_d             = DONE;
                end
            end
            HI: begin
                result_d[2*HW-1:HW] = alu_out;
                carry_d             = alu_c_out;
                state_d             = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            cin_q    <= 1'b0;
            wide_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            cin_q    <= cin_d;
            wide_q   <= wide_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    // The high half chains the carry produced by the low half, not the request carry.
    always_comb begin
        alu_a_in = '0;
        alu_b_in = '0;
        alu_c_in = 1'b0;
        alu_sel  = '0;
        case (state_q)
            LO: begin
                alu_a_in = a_q[HW-1:0];
                alu_b_in = b_q[HW-1:0];
                alu_c_in = cin_q;
                alu_sel  = sel_q;
            end
            HI: begin
                alu_a_in = a_q[2*HW-1:HW];
                alu_b_in = b_q[2*HW-1:HW];
                alu_c_in = carry_q;
                alu_sel  = sel_q;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_out   = result_q;
    assign rsp_c_out = carry_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU drives the DUT's ALU port, and every
// response is compared against whole-word arithmetic computed in the bench.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_sel;
   logic        req_c_in;
   logic        req_wide;
   logic [15:0] alu_a_in;
   logic [15:0] alu_b_in;
   logic        alu_c_in;
   logic [3:0]  alu_sel;
   logic [15:0] alu_out;
   logic        alu_c_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_out;
   logic        rsp_c_out;
   logic        busy;

   int totalChecks = 0;
   int badChecks = 0;

   alu_seq_ctrl #(.HW(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .req_c_in(req_c_in), .req_wide(req_wide),
      .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_c_in(alu_c_in), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_c_out(alu_c_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_c_out(rsp_c_out), .busy(busy)
   );

   always #5 clk = ~clk;

   // Half-word ALU: 0 add, 1 and (carry passes through), 2 or, 3 xor (carry = sign of a)
   always_comb begin
      alu_out   = alu_a_in;
      alu_c_out = 1'b0;
      case (alu_sel)
         4'd0: {alu_c_out, alu_out} = {1'b0, alu_a_in} + {1'b0, alu_b_in} + 17'(alu_c_in);
         4'd1: begin alu_out = alu_a_in & alu_b_in; alu_c_out = alu_c_in; end
         4'd2: alu_out = alu_a_in | alu_b_in;
         4'd3: begin alu_out = alu_a_in ^ alu_b_in; alu_c_out = alu_a_in[15]; end
         default: ;
      endcase
   end

   // Whole-operation expectation computed directly on 32-bit values
   function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] sel, input logic cin, input logic wide,
                                    output logic [31:0] res, output logic co);
      logic [32:0] s33;
      logic [16:0] s17;
      res = 32'h0;
      co  = 1'b0;
      case (sel)
         4'd0: begin
            if (wide) begin
               s33 = {1'b0, a} + {1'b0, b} + 33'(cin);
               res = s33[31:0];
               co  = s33[32];
            end else begin
               s17 = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(cin);
               res = {16'h0, s17[15:0]};
               co  = s17[16];
            end
         end
         4'd1: begin res = a & b; co = cin; end
         4'd2: begin res = a | b; co = 1'b0; end
         4'd3: begin res = a ^ b; co = wide ? a[31] : a[15]; end
         default: ;
      endcase
      if (!wide) res[31:16] = 16'h0;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One full request/response transaction with latency, drive and result checks
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                                input logic cin, input logic wide, input int stall, input string name);
      logic [31:0] expRes;
      logic        expCo;
      int          n;
      refModel(a, b, sel, cin, wide, expRes, expCo);
      n = 0;
      while (!req_ready && n < 50) begin cyc(); n++; end
      totalChecks++;
      if (req_ready !== 1'b1) begin
         badChecks++;
         $display("[TB] FAIL %s ready_wait: req_ready=%b want 1", name, req_ready);
      end
      req_a = a; req_b = b; req_sel = sel; req_c_in = cin; req_wide = wide;
      req_valid = 1'b1; rsp_ready = 1'b0;
      cyc();
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_sel = 4'($urandom);
      req_c_in = 1'($urandom); req_wide = 1'($urandom);
      totalChecks++;
      if (alu_a_in !== a[15:0] || alu_b_in !== b[15:0] || alu_c_in !== cin || alu_sel !== sel) begin
         badChecks++;
         $display("[TB] FAIL %s lo_drive: got a=%h b=%h c=%b sel=%h want a=%h b=%h c=%b sel=%h",
                  name, alu_a_in, alu_b_in, alu_c_in, alu_sel, a[15:0], b[15:0], cin, sel);
      end
      n = 1;
      while (!rsp_valid && n < 10) begin cyc(); n++; end
      totalChecks++;
      if (n != (wide ? 3 : 2) || rsp_valid !== 1'b1) begin
         badChecks++;
         $display("[TB] FAIL %s latency: got %0d want %0d", name, n, wide ? 3 : 2);
      end
      totalChecks++;
      if (rsp_out !== expRes || rsp_c_out !== expCo) begin
         badChecks++;
         $display("[TB] FAIL %s result: got %h/%b want %h/%b", name, rsp_out, rsp_c_out, expRes, expCo);
      end
      totalChecks++;
      if (alu_a_in !== 16'h0 || alu_b_in !== 16'h0 || alu_c_in !== 1'b0 || alu_sel !== 4'h0) begin
         badChecks++;
         $display("[TB] FAIL %s done_alu_idle: got a=%h b=%h c=%b sel=%h want zeros",
                  name, alu_a_in, alu_b_in, alu_c_in, alu_sel);
      end
      for (int i = 0; i < stall; i++) begin
         cyc();
         totalChecks++;
         if (rsp_valid !== 1'b1 || rsp_out !== expRes || req_ready !== 1'b0) begin
            badChecks++;
            $display("[TB] FAIL %s stall_hold: got v=%b out=%h rdy=%b want 1/%h/0",
                     name, rsp_valid, rsp_out, req_ready, expRes);
         end
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      totalChecks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         badChecks++;
         $display("[TB] FAIL %s handshake: got v=%b busy=%b rdy=%b want 0/0/1",
                  name, rsp_valid, busy, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_sel = '0; req_c_in = 1'b0; req_wide = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      totalChecks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
          rsp_out !== 32'h0 || rsp_c_out !== 1'b0) begin
         badChecks++;
         $display("[TB] FAIL reset_state: got rdy=%b busy=%b v=%b out=%h c=%b want 1/0/0/0/0",
                  req_ready, busy, rsp_valid, rsp_out, rsp_c_out);
      end
      totalChecks++;
      if (alu_a_in !== 16'h0 || alu_b_in !== 16'h0 || alu_c_in !== 1'b0 || alu_sel !== 4'h0) begin
         badChecks++;
         $display("[TB] FAIL reset_alu: got a=%h b=%h c=%b sel=%h want zeros",
                  alu_a_in, alu_b_in, alu_c_in, alu_sel);
      end
   endtask

   task automatic test_directed();
      applyStimulus(32'h0000FFFF, 32'h00000001, 4'd0, 1'b0, 1'b1, 0, "wide_add_carry");
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 1'b1, 1'b1, 0, "wide_add_all_ones");
      applyStimulus(32'h12340009, 32'h56780007, 4'd0, 1'b1, 1'b0, 0, "narrow_add");
   endtask

   task automatic test_stall();
      applyStimulus(32'h12340009, 32'h56780007, 4'd0, 1'b1, 1'b0, 5, "stall_narrow");
      req_a = 32'h00010001; req_b = 32'h00010001; req_sel = 4'd0; req_c_in = 1'b0; req_wide = 1'b1;
      applyStimulus(32'hDEADBEEF, 32'h0F0F0F0F, 4'd3, 1'b0, 1'b1, 0, "after_stall_prep");
      req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = 32'h0000000A; req_b = 32'h00000005; req_sel = 4'd0; req_c_in = 1'b0; req_wide = 1'b0;
      req_valid = 1'b1;
      cyc();
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) cyc();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            req_valid = 1'b1; req_a = 32'h77777777; req_b = 32'h11111111;
            req_sel = 4'd2; req_c_in = 1'b1; req_wide = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         cyc();
         totalChecks++;
         if (rsp_valid !== 1'b1 || rsp_out !== 32'h0000000F || rsp_c_out !== 1'b0 || req_ready !== 1'b0) begin
            badChecks++;
            $display("[TB] FAIL stall_pulse_hold: got v=%b out=%h c=%b rdy=%b want 1/0000000f/0/0",
                     rsp_valid, rsp_out, rsp_c_out, req_ready);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         totalChecks++;
         if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            badChecks++;
            $display("[TB] FAIL stall_pulse_ignored: got busy=%b v=%b want 0/0", busy, rsp_valid);
         end
      end
   endtask

   task automatic test_reset_in_hi();
      req_a = 32'h11112222; req_b = 32'h33334444; req_sel = 4'd0; req_c_in = 1'b1; req_wide = 1'b1;
      req_valid = 1'b1;
      cyc();
      req_valid = 1'b0;
      cyc();
      totalChecks++;
      if (busy !== 1'b1 || alu_a_in !== 16'h1111 || alu_b_in !== 16'h3333) begin
         badChecks++;
         $display("[TB] FAIL hi_drive: got busy=%b a=%h b=%h want 1/1111/3333", busy, alu_a_in, alu_b_in);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      totalChecks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_out !== 32'h0 || rsp_c_out !== 1'b0 || req_ready !== 1'b1) begin
         badChecks++;
         $display("[TB] FAIL reset_in_hi: got busy=%b v=%b out=%h c=%b rdy=%b want 0/0/0/0/1",
                  busy, rsp_valid, rsp_out, rsp_c_out, req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         cyc();
         totalChecks++;
         if (rsp_valid !== 1'b0) begin
            badChecks++;
            $display("[TB] FAIL reset_no_rsp: got v=%b want 0", rsp_valid);
         end
      end
      applyStimulus(32'h0001FFFF, 32'h00020001, 4'd0, 1'b0, 1'b1, 1, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [31:0] e1, e2;
      logic        c1, c2;
      int          n;
      refModel(32'hA5A5F00F, 32'h5A5A1FF1, 4'd0, 1'b1, 1'b1, e1, c1);
      refModel(32'h0000C000, 32'h00004001, 4'd0, 1'b0, 1'b0, e2, c2);
      rsp_ready = 1'b1;
      req_a = 32'hA5A5F00F; req_b = 32'h5A5A1FF1; req_sel = 4'd0; req_c_in = 1'b1; req_wide = 1'b1;
      req_valid = 1'b1;
      cyc();
      req_a = 32'h0000C000; req_b = 32'h00004001; req_c_in = 1'b0; req_wide = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin cyc(); n++; end
      totalChecks++;
      if (rsp_valid !== 1'b1 || rsp_out !== e1 || rsp_c_out !== c1) begin
         badChecks++;
         $display("[TB] FAIL b2b_first: got v=%b %h/%b want 1 %h/%b", rsp_valid, rsp_out, rsp_c_out, e1, c1);
      end
      cyc();
      totalChecks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         badChecks++;
         $display("[TB] FAIL b2b_gap: got rdy=%b busy=%b want 1/0", req_ready, busy);
      end
      cyc();
      req_valid = 1'b0;
      totalChecks++;
      if (busy !== 1'b1 || alu_a_in !== 16'hC000 || alu_c_in !== 1'b0) begin
         badChecks++;
         $display("[TB] FAIL b2b_second_accept: got busy=%b a=%h c=%b want 1/c000/0", busy, alu_a_in, alu_c_in);
      end
      n = 0;
      while (!rsp_valid && n < 10) begin cyc(); n++; end
      totalChecks++;
      if (rsp_valid !== 1'b1 || rsp_out !== e2 || rsp_c_out !== c2) begin
         badChecks++;
         $display("[TB] FAIL b2b_second: got v=%b %h/%b want 1 %h/%b", rsp_valid, rsp_out, rsp_c_out, e2, c2);
      end
      cyc();
      rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         applyStimulus($urandom, $urandom, 4'($urandom_range(0, 3)), 1'($urandom),
                       1'($urandom), int'($urandom_range(0, 2)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_reset_in_hi();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter HW, default 16, giving the ALU half-word width; the operand/result width is 2*HW.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-006 SHALL have port req_a, input, 2*HW, operand A.
REQ-007 SHALL have port req_b, input, 2*HW, operand B.
REQ-008 SHALL have port req_sel, input, 4, ALU operation code, passed unchanged to alu_sel.
REQ-009 SHALL have port req_c_in, input, 1, carry into the low half.
REQ-010 SHALL have port req_wide, input, 1: 1 = two-half (2*HW) operation; 0 = single-half (HW) operation.
REQ-011 SHALL have port alu_a_in, output, HW, driven to the ALU a_in.
REQ-012 SHALL have port alu_b_in, output, HW, driven to the ALU b_in.
REQ-013 SHALL have port alu_c_in, output, 1, driven to the ALU c_in.
REQ-014 SHALL have port alu_sel, output, 4, driven to the ALU alu_sel.
REQ-015 SHALL have port alu_out, input, HW, combinational ALU result.
REQ-016 SHALL have port alu_c_out, input, 1, combinational ALU carry out.
REQ-017 SHALL have port rsp_valid, output, 1, result available.
REQ-018 SHALL have port rsp_ready, input, 1, consumer accepts the result.
REQ-019 SHALL have port rsp_out, output, 2*HW, the result.
REQ-020 SHALL have port rsp_c_out, output, 1, final carry.
REQ-021 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-022 SHALL implement the FSM states IDLE, LO, HI and DONE.
REQ-023 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both high on a clock edge.
REQ-024 SHALL register req_a, req_b, req_sel, req_c_in and req_wide on acceptance; later changes to the inputs SHALL NOT affect the operation in progress.
REQ-025 SHALL transition IDLE->LO on acceptance; otherwise it remains in IDLE.
REQ-026 SHALL, in LO, drive: alu_a_in = A[HW-1:0], alu_b_in = B[HW-1:0], alu_c_in = latched c_in, alu_sel = latched sel.
REQ-027 SHALL, at the end of LO, capture alu_out into result[HW-1:0] and alu_c_out into the carry register.
REQ-028 SHALL, at the end of LO, transition to HI if wide = 1, else to DONE.
REQ-029 SHALL, for a narrow operation, clear result[2*HW-1:HW] to 0.
REQ-030 SHALL, in HI, drive: alu_a_in = A[2*HW-1:HW], alu_b_in = B[2*HW-1:HW], alu_c_in = the carry captured in LO, alu_sel = latched sel.
REQ-031 SHALL, at the end of HI, capture alu_out into result[2*HW-1:HW], update the carry register, and transition to DONE.
REQ-032 SHALL, in DONE, hold rsp_valid = 1, with rsp_out and rsp_c_out stable, until rsp_ready is sampled high; then it SHALL transition to IDLE.
REQ-033 SHALL NOT accept a request in the DONE->IDLE transition cycle; the earliest acceptance is in the cycle after the state reaches IDLE.
REQ-034 SHALL have latency from acceptance edge to rsp_valid high of 3 cycles for wide operations and 2 cycles for narrow operations.
REQ-035 SHALL, in IDLE and DONE, drive alu_a_in, alu_b_in, alu_c_in and alu_sel to 0.
REQ-036 SHALL ignore a req_valid asserted while busy; it SHALL be neither accepted nor lost (req_ready stays low).
REQ-037 SHALL capture the carry unchanged; carry semantics for non-arithmetic opcodes are the ALU's.

Reset
REQ-038 SHALL, when rst is high at a clock edge, enter IDLE and force rsp_valid = 0, rsp_out = 0, rsp_c_out = 0, busy = 0 and the internal carry to 0; req_ready SHALL be 1 from the next cycle.
REQ-039 SHALL give rst priority over all other inputs; a reset in LO, HI or DONE SHALL discard the operation, and no response SHALL be issued for it.

Verification
REQ-040 SHALL cover: wide, sel = 0 (ADD), A = 0x0000FFFF, B = 0x00000001, c_in = 0 -> rsp_out = 0x00010000, rsp_c_out = 0, rsp_valid 3 cycles after acceptance.
REQ-041 SHALL cover: wide ADD, A = B = 0xFFFFFFFF, c_in = 1 -> rsp_out = 0xFFFFFFFF, rsp_c_out = 1.
REQ-042 SHALL cover: narrow ADD, A = 0x12340009, B = 0x56780007, c_in = 1 -> rsp_out = 0x00000011, rsp_c_out = 0, rsp_valid after 2 cycles.
REQ-043 SHALL cover: rsp_ready held low for 5 cycles in DONE -> rsp_valid and rsp_out stable, req_ready low, and a req_valid pulse is not accepted.
REQ-044 SHALL cover: rst asserted in HI -> next cycle IDLE, rsp_valid = 0, no response; a subsequent request completes correctly.
REQ-045 SHALL cover: back-to-back requests with req_valid held high -> the second is accepted exactly one cycle after the first response handshake.
